// File: rtl/div_arbiter_if.sv
// Bundle of signals between the requesters, the divider arbiter and the shared iterative divider.
// The arbiter uses the slave modport; the requester/divider side uses the master modport.
interface div_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [1:0]            rsp_err;
    logic                  busy;
    logic [WIDTH-1:0]      div_x;
    logic [WIDTH-1:0]      div_y;
    logic                  div_start;
    logic                  div_done;
    logic [WIDTH-1:0]      div_quotient;

    modport slave (
        input  req_valid, req_x, req_y, div_done, div_quotient,
        output req_ready, rsp_valid, rsp_quotient, rsp_err, busy, div_x, div_y, div_start
    );

    modport master (
        output req_valid, req_x, req_y, div_done, div_quotient,
        input  req_ready, rsp_valid, rsp_quotient, rsp_err, busy, div_x, div_y, div_start
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider among NREQ requesters,
// with divide-by-zero trapping and a watchdog on every launched operation.
//
// state  | meaning
// IDLE   | offering grant to next requester after rr_ptr
// LAUNCH | div_start pulse, watchdog cleared
// WAIT   | divider running, watchdog counting
// RESP   | one-cycle rsp_valid to the granted requester
module div_arbiter #(
    parameter int NREQ           = 4,
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 70000,
    parameter int TW             = 17
) (
    input logic          clk,
    input logic          rst,
    div_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q;
    logic [IDW-1:0]    rr_ptr_q;
    logic [IDW-1:0]    id_q;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  y_q;
    logic [WIDTH-1:0]  quot_q;
    logic [1:0]        err_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic              div_start_q;
    logic [TW-1:0]     timer_q;

    logic              grant_found;
    logic [IDW-1:0]    grant_id;
    logic [NREQ-1:0]   grant_oh;
    logic [NREQ-1:0]   id_oh;
    logic [WIDTH-1:0]  grant_x;
    logic [WIDTH-1:0]  grant_y;
    int                idx;

    // Scan downward so the lowest offset from rr_ptr+1 is the one that sticks.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign grant_oh = NREQ'(1) << grant_id;
    assign id_oh    = NREQ'(1) << id_q;
    assign grant_x  = bus.req_x[int'(grant_id)*WIDTH +: WIDTH];
    assign grant_y  = bus.req_y[int'(grant_id)*WIDTH +: WIDTH];

    assign bus.req_ready    = (state_q == S_IDLE && grant_found) ? grant_oh : '0;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_quotient = quot_q;
    assign bus.rsp_err      = err_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.div_x        = x_q;
    assign bus.div_y        = y_q;
    assign bus.div_start    = div_start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            id_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            quot_q      <= '0;
            err_q       <= 2'b00;
            rsp_valid_q <= '0;
            div_start_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        x_q  <= grant_x;
                        y_q  <= grant_y;
                        id_q <= grant_id;
                        // A zero divisor would hang the divider, so answer directly.
                        if (grant_y == '0) begin
                            quot_q      <= '1;
                            err_q       <= 2'b01;
                            rsp_valid_q <= grant_oh;
                            state_q     <= S_RESP;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    div_start_q <= 1'b0;
                    timer_q     <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_q + TW'(1);
                    if (bus.div_done) begin
                        quot_q      <= bus.div_quotient;
                        err_q       <= 2'b00;
                        rsp_valid_q <= id_oh;
                        state_q     <= S_RESP;
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        quot_q      <= '1;
                        err_q       <= 2'b10;
                        rsp_valid_q <= id_oh;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
                    rr_ptr_q    <= id_q;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// Randomized bench for div_arbiter: a behavioural divider answers launches, and a
// round-robin/arithmetic reference predicts grants, quotients, errors and latencies.
module tb_div_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TO   = 50;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    int   div_mode  = 1;   // 0 never answers, 1 random delay, 2 fixed delay
    int   div_delay = 5;
    int   starts = 0;
    int   last_start = 0;
    int   m_last = NREQ - 1;

    logic         dm_pending;
    int           dm_cnt;
    logic [W-1:0] dm_q;

    div_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

    div_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT_CYCLES(TO), .TW(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural divider: answers each start pulse after a delay with x/y.
    initial begin
        dm_pending = 1'b0;
        dm_cnt = 0;
        dm_q = '0;
        bus.div_done = 1'b0;
        bus.div_quotient = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.div_done = 1'b0;
            if (dm_pending) begin
                if (dm_cnt == 0) begin
                    bus.div_done = 1'b1;
                    bus.div_quotient = dm_q;
                    dm_pending = 1'b0;
                end else dm_cnt--;
            end
            if (bus.div_start === 1'b1) begin
                starts++;
                last_start = cyc;
                if (div_mode != 0) begin
                    dm_pending = 1'b1;
                    dm_q = (bus.div_y == 0) ? '1 : bus.div_x / bus.div_y;
                    dm_cnt = ((div_mode == 1) ? int'($urandom_range(1, 20)) : div_delay) - 1;
                end
            end
        end
    end

    function automatic int rr_next(input int last, input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++)
            if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic do_req(input int id, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int t, output logic ok);
        @(posedge clk);
        #1;
        bus.req_x[id*W +: W] = x;
        bus.req_y[id*W +: W] = y;
        bus.req_valid[id] = 1'b1;
        ok = 1'b0;
        t = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready[id] === 1'b1) begin
                ok = 1'b1;
                t = cyc;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int lim, output logic ok, output logic [NREQ-1:0] rv,
                            output logic [W-1:0] q, output logic [1:0] e, output int c);
        ok = 1'b0; rv = '0; q = '0; e = '0; c = 0;
        for (int k = 0; k < lim && !ok; k++) begin
            @(negedge clk);
            if (|bus.rsp_valid) begin
                ok = 1'b1; rv = bus.rsp_valid; q = bus.rsp_quotient; e = bus.rsp_err; c = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.rsp_valid !== 4'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
        vectors++; if (bus.div_start !== 1'b0) begin miscompares++; $display("FAIL reset_div_start: got %b want 0", bus.div_start); end
        vectors++; if ({bus.div_x, bus.div_y, bus.rsp_quotient} !== 48'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {bus.div_x, bus.div_y, bus.rsp_quotient}); end
        vectors++; if (bus.rsp_err !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b want 00", bus.rsp_err); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_last = NREQ - 1;
    endtask

    task automatic test_single();
        int t, c, s0; logic ok, rok; logic [NREQ-1:0] rv; logic [W-1:0] q; logic [1:0] e;
        div_mode = 2; div_delay = 5; s0 = starts;
        do_req(0, 16'd100, 16'd7, t, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_accept: got no ready want ready"); end
        vectors++; if (bus.div_x !== 16'd100 || bus.div_y !== 16'd7) begin miscompares++; $display("FAIL single_operands: got %0d/%0d want 100/7", bus.div_x, bus.div_y); end
        wait_rsp(100, rok, rv, q, e, c);
        vectors++; if (!rok || rv !== 4'b0001 || q !== 16'd14 || e !== 2'b00) begin miscompares++; $display("FAIL single_rsp: got ok=%b rv=%b q=%0d e=%b want rv=0001 q=14 e=00", rok, rv, q, e); end
        vectors++; if (starts - s0 != 1 || last_start != t + 1 || c != t + 7) begin miscompares++; $display("FAIL single_timing: got starts=%0d launch=%0d rsp=%0d want 1 %0d %0d", starts - s0, last_start, c, t + 1, t + 7); end
        m_last = 0;
    endtask

    task automatic test_divzero();
        int t, c, s0; logic ok, rok; logic [NREQ-1:0] rv; logic [W-1:0] q; logic [1:0] e;
        s0 = starts;
        do_req(2, 16'd55, 16'd0, t, ok);
        wait_rsp(20, rok, rv, q, e, c);
        vectors++; if (!ok || !rok || rv !== 4'b0100 || q !== 16'hFFFF || e !== 2'b01) begin miscompares++; $display("FAIL divzero_rsp: got ok=%b rv=%b q=%h e=%b want rv=0100 q=ffff e=01", rok, rv, q, e); end
        vectors++; if (c != t + 1 || starts != s0) begin miscompares++; $display("FAIL divzero_timing: got rsp=%0d starts=%0d want %0d 0", c, starts - s0, t + 1); end
        m_last = 2;
    endtask

    task automatic test_fairness();
        logic [W-1:0] fx [NREQ];
        logic [W-1:0] fy [NREQ];
        logic [NREQ-1:0] acc, rv; logic [W-1:0] q; logic [1:0] e; logic ok; int c;
        div_mode = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            fx[i] = W'($urandom); fy[i] = W'($urandom_range(1, 65535));
            bus.req_x[i*W +: W] = fx[i]; bus.req_y[i*W +: W] = fy[i];
        end
        bus.req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            acc = '0;
            for (int k = 0; k < 100 && acc == 0; k++) begin
                @(negedge clk);
                acc = bus.req_valid & bus.req_ready;
            end
            vectors++; if (acc !== (NREQ'(1) << (n % NREQ))) begin miscompares++; $display("FAIL fair_grant%0d: got %b want %b", n, acc, NREQ'(1) << (n % NREQ)); end
            wait_rsp(100, ok, rv, q, e, c);
            vectors++; if (!ok || rv !== acc || q !== fx[n % NREQ] / fy[n % NREQ] || e !== 2'b00) begin miscompares++; $display("FAIL fair_rsp%0d: got rv=%b q=%h e=%b want q=%h", n, rv, q, e, fx[n % NREQ] / fy[n % NREQ]); end
        end
        bus.req_valid = '0;
        m_last = 0;
        @(posedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] rx [NREQ];
        logic [W-1:0] ry [NREQ];
        logic [NREQ-1:0] mask, rv; logic [W-1:0] q, eq; logic [1:0] e, ee; logic ok; int g, t, c, s0;
        div_mode = 1;
        for (int it = 0; it < 30; it++) begin
            @(posedge clk);
            #1;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                rx[i] = W'($urandom);
                ry[i] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 300));
                bus.req_x[i*W +: W] = rx[i]; bus.req_y[i*W +: W] = ry[i];
            end
            bus.req_valid = mask;
            g = rr_next(m_last, mask);
            s0 = starts;
            @(negedge clk);
            t = cyc;
            vectors++; if (bus.req_ready !== (NREQ'(1) << g)) begin miscompares++; $display("FAIL rand_ready%0d: got %b want %b", it, bus.req_ready, NREQ'(1) << g); end
            @(posedge clk);
            #1;
            bus.req_valid = '0;
            eq = (ry[g] == 0) ? '1 : rx[g] / ry[g];
            ee = (ry[g] == 0) ? 2'b01 : 2'b00;
            wait_rsp(100, ok, rv, q, e, c);
            vectors++; if (!ok || rv !== (NREQ'(1) << g) || q !== eq || e !== ee) begin miscompares++; $display("FAIL rand_rsp%0d: got rv=%b q=%h e=%b want rv=%b q=%h e=%b", it, rv, q, e, NREQ'(1) << g, eq, ee); end
            if (ry[g] == 0) begin
                vectors++; if (c != t + 1 || starts != s0) begin miscompares++; $display("FAIL rand_dz_timing%0d: got rsp=%0d starts=%0d want %0d 0", it, c, starts - s0, t + 1); end
            end
            m_last = g;
        end
    endtask

    task automatic test_timeout();
        int t, c; logic ok, rok; logic [NREQ-1:0] rv; logic [W-1:0] q; logic [1:0] e;
        div_mode = 0;
        do_req(1, 16'd9, 16'd3, t, ok);
        wait_rsp(100, rok, rv, q, e, c);
        vectors++; if (!ok || !rok || rv !== 4'b0010 || q !== 16'hFFFF || e !== 2'b10) begin miscompares++; $display("FAIL timeout_rsp: got rv=%b q=%h e=%b want 0010 ffff 10", rv, q, e); end
        vectors++; if (c != last_start + TO + 1) begin miscompares++; $display("FAIL timeout_timing: got rsp=%0d want %0d", c, last_start + TO + 1); end
        div_mode = 2; div_delay = 3;
        do_req(2, 16'd81, 16'd9, t, ok);
        wait_rsp(100, rok, rv, q, e, c);
        vectors++; if (!ok || !rok || rv !== 4'b0100 || q !== 16'd9 || e !== 2'b00) begin miscompares++; $display("FAIL after_timeout_rsp: got rv=%b q=%0d e=%b want 0100 9 00", rv, q, e); end
        m_last = 2;
    endtask

    task automatic test_collision();
        int t, c; logic ok, rok; logic [NREQ-1:0] rv; logic [W-1:0] q; logic [1:0] e;
        div_mode = 2; div_delay = TO;
        do_req(3, 16'd1000, 16'd10, t, ok);
        wait_rsp(100, rok, rv, q, e, c);
        vectors++; if (!ok || !rok || rv !== 4'b1000 || q !== 16'd100 || e !== 2'b00 || c != last_start + TO + 1) begin miscompares++; $display("FAIL collision_rsp: got rv=%b q=%0d e=%b rsp=%0d want 1000 100 00 %0d", rv, q, e, c, last_start + TO + 1); end
        m_last = 3;
    endtask

    task automatic test_reset_mid();
        int t, c; logic ok, rok; logic [NREQ-1:0] rv; logic [W-1:0] q; logic [1:0] e;
        div_mode = 0;
        do_req(1, 16'd5, 16'd1, t, ok);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0) begin miscompares++; $display("FAIL midreset_outputs: got busy=%b rv=%b want 0 0000", bus.busy, bus.rsp_valid); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_last = NREQ - 1;
        div_mode = 2; div_delay = 4;
        bus.req_x[0*W +: W] = 16'd500; bus.req_y[0*W +: W] = 16'd4;
        bus.req_x[2*W +: W] = 16'd7;   bus.req_y[2*W +: W] = 16'd7;
        bus.req_valid = 4'b0101;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL midreset_priority: got %b want 0001", bus.req_ready); end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        wait_rsp(100, rok, rv, q, e, c);
        vectors++; if (!rok || rv !== 4'b0001 || q !== 16'd125 || e !== 2'b00) begin miscompares++; $display("FAIL midreset_rsp: got rv=%b q=%0d e=%b want 0001 125 00", rv, q, e); end
    endtask

    initial begin
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        test_reset();
        test_single();
        test_divzero();
        test_fairness();
        test_random();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
